hilo_mul_ctrl: RTL

- Sits between the decode/execute stage and the 32-bit Booth multiplier (mul_* ports).
- Accepts MULT/MULTU/MTHI/MTLO ops from the pipeline and holds operands stable for the whole multiply.
- Runs the multiplier's Start/Ready level handshake, converts signed products to unsigned for MULTU, and owns the architectural HI/LO registers.
- Tells the pipeline when HI/LO reads must stall.

---
 rtl/hilo_pkg.sv | 30 +++
 rtl/mulu_fixup.sv | 54 +++++
 rtl/hilo_mul_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply controller: op codes, FSM states, defaults.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package hilo_pkg;

    // Pipeline op codes
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b010;
    localparam logic [2:0] OP_MTLO  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;

    // Maximum cycles spent in LAUNCH+BUSY before the operation is aborted
    localparam int TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_FIX    = 2'd3
    } state_e;

    // How the raw multiplier result is folded into HI/LO in FIX
    typedef enum logic [1:0] {
        K_MULT  = 2'd0,
        K_MULTU = 2'd1,
        K_MADD  = 2'd2
    } kind_e;

endpackage

// File: rtl/mulu_fixup.sv
// Result shaping for the signed Booth multiplier: unsigned HI correction and optional MADD accumulate.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: x_i/y_i latched operands, mul_hi_i/mul_lo_i raw signed product, acc_hi_i/acc_lo_i
// current HI/LO, kind_i result kind, hi_o/lo_o values to load into HI/LO.
// Optional feature macro: HILO_MADD_EN (adds the 2*WIDTH accumulate adder).
module mulu_fixup
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [WIDTH-1:0] mul_hi_i,
    input  logic [WIDTH-1:0] mul_lo_i,
    input  logic [WIDTH-1:0] acc_hi_i,
    input  logic [WIDTH-1:0] acc_lo_i,
    input  kind_e            kind_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    // A signed product differs from the unsigned one only in the upper half:
    // each operand with its MSB set contributes the other operand * 2^WIDTH.
    logic [WIDTH-1:0] hi_unsigned;
    assign hi_unsigned = mul_hi_i
                       + (x_i[WIDTH-1] ? y_i : '0)
                       + (y_i[WIDTH-1] ? x_i : '0);

`ifdef HILO_MADD_EN
    logic [2*WIDTH-1:0] acc_sum;
    assign acc_sum = {acc_hi_i, acc_lo_i} + {mul_hi_i, mul_lo_i};
`else
    logic unused_acc;
    assign unused_acc = ^{acc_hi_i, acc_lo_i};
`endif

    always_comb begin
        hi_o = mul_hi_i;
        lo_o = mul_lo_i;
        case (kind_i)
            K_MULTU: hi_o = hi_unsigned;
`ifdef HILO_MADD_EN
            K_MADD: begin
                hi_o = acc_sum[2*WIDTH-1:WIDTH];
                lo_o = acc_sum[WIDTH-1:0];
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/hilo_mul_ctrl.sv
// HI/LO register owner: launches MULT/MULTU(/MADD) on the Booth multiplier, executes MTHI/MTLO.
// Latency: MTHI/MTLO 1 cycle; multiplies update HI/LO one cycle after mul_ready_i is seen high.
// Backpressure: op_ready_o is high only in IDLE; the pipeline holds its op while busy_o is high.
//
// Ports: clk_i/rst_n_i clock and async active-low reset; op_valid_i/op_ready_o/op_code_i/
// rs_val_i/rt_val_i op handshake; hi_out_o/lo_out_o architectural HI/LO; busy_o HI/LO pending;
// timeout_err_o sticky abort flag; mul_x_o/mul_y_o/mul_start_o/mul_hi_i/mul_lo_i/mul_ready_i
// multiplier interface (level Start/Ready handshake).
// Optional feature macro: HILO_MADD_EN (op code 100 = signed multiply-accumulate).
module hilo_mul_ctrl
    import hilo_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [2:0]       op_code_i,
    input  logic [WIDTH-1:0] rs_val_i,
    input  logic [WIDTH-1:0] rt_val_i,
    output logic [WIDTH-1:0] hi_out_o,
    output logic [WIDTH-1:0] lo_out_o,
    output logic             busy_o,
    output logic             timeout_err_o,
    output logic [WIDTH-1:0] mul_x_o,
    output logic [WIDTH-1:0] mul_y_o,
    output logic             mul_start_o,
    input  logic [WIDTH-1:0] mul_hi_i,
    input  logic [WIDTH-1:0] mul_lo_i,
    input  logic             mul_ready_i
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e           state_q;
    kind_e            kind_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, x_q, y_q;
    logic             start_q, busy_q, ready_q, terr_q;

    // Op decode: which codes start a multiply and how their result is folded in
    logic  dec_mul;
    kind_e dec_kind;

    always_comb begin
        dec_mul  = 1'b0;
        dec_kind = K_MULT;
        case (op_code_i)
            OP_MULT:  dec_mul = 1'b1;
            OP_MULTU: begin
                dec_mul  = 1'b1;
                dec_kind = K_MULTU;
            end
`ifdef HILO_MADD_EN
            OP_MADD: begin
                dec_mul  = 1'b1;
                dec_kind = K_MADD;
            end
`endif
            default: ;
        endcase
    end

    logic [WIDTH-1:0] fix_hi, fix_lo;

    mulu_fixup #(.WIDTH(WIDTH)) u_fixup (
        .x_i      (x_q),
        .y_i      (y_q),
        .mul_hi_i (mul_hi_i),
        .mul_lo_i (mul_lo_i),
        .acc_hi_i (hi_q),
        .acc_lo_i (lo_q),
        .kind_i   (kind_q),
        .hi_o     (fix_hi),
        .lo_o     (fix_lo)
    );

    logic accept;
    assign accept = op_valid_i && ready_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            kind_q  <= K_MULT;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (op_code_i == OP_MTHI) begin
                            hi_q <= rs_val_i;
                        end else if (op_code_i == OP_MTLO) begin
                            lo_q <= rs_val_i;
                        end else if (dec_mul) begin
                            x_q     <= rs_val_i;
                            y_q     <= rt_val_i;
                            kind_q  <= dec_kind;
                            cnt_q   <= '0;
                            start_q <= 1'b1;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b0;
                            state_q <= ST_LAUNCH;
                        end
                        // any other code is consumed without effect
                    end
                end
                ST_LAUNCH: begin
                    if (cnt_q == CNT_LAST) begin
                        terr_q  <= 1'b1;
                        start_q <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        // Ready still high here is left over from the previous op;
                        // only its fall proves this Start was taken.
                        if (!mul_ready_i) begin
                            state_q <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mul_ready_i) begin
                        start_q <= 1'b0;
                        state_q <= ST_FIX;
                    end else if (cnt_q == CNT_LAST) begin
                        terr_q  <= 1'b1;
                        start_q <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_FIX: begin
                    // Start is already low this cycle, guaranteeing a low gap before relaunch
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign op_ready_o    = ready_q;
    assign hi_out_o      = hi_q;
    assign lo_out_o      = lo_q;
    assign busy_o        = busy_q;
    assign timeout_err_o = terr_q;
    assign mul_x_o       = x_q;
    assign mul_y_o       = y_q;
    assign mul_start_o   = start_q;

endmodule
